reg_sequencer: RTL

Multi-cycle control sequencer for the byter register module. It accepts 16-bit instructions over a valid/ready handshake and decodes each one. It then drives the register module's write strobes (`regEn`, `litEn`, `memEn`), its read selects (`SA`, `SB`) and its literal bus, and runs a req/ack handshake to data memory for loads and stores. It sits between instruction fetch and `reg_module`/ALU, and reports a retire pulse and a wrapping retire count.

---
 rtl/reg_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reg_sequencer.sv
// Control sequencer for the byter register module: accepts 16-bit instructions,
// drives register-file selects/strobes and a req/ack data-memory handshake.
module reg_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              regEn,
    output logic              litEn,
    output logic              memEn,
    output logic [3:0]        SA,
    output logic [3:0]        SB,
    output logic [7:0]        lit,
    output logic [3:0]        alu_op,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_MEMW, S_MEMWB} state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ALU = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;

    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             accept;

    logic [3:0] op, rd, rs, aop;
    logic [7:0] imm8;

    assign op   = ir_q[15:12];
    assign rd   = ir_q[11:8];
    assign rs   = ir_q[7:4];
    assign aop  = ir_q[3:0];
    assign imm8 = ir_q[7:0];

    assign accept  = instr_valid && (state_q == S_IDLE);
    assign illegal = illegal_q;
    assign retired = retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        regEn       = 1'b0;
        litEn       = 1'b0;
        memEn       = 1'b0;
        SA          = '0;
        SB          = '0;
        lit         = '0;
        alu_op      = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    case (instr[15:12])
                        OP_ALU:       state_d = S_READ;
                        OP_LD, OP_ST: state_d = S_MEMW;
                        default:      state_d = S_WRITE;
                    endcase
                end
            end
            S_READ: begin
                SA      = rd;
                SB      = rs;
                alu_op  = aop;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // NOP and illegal opcodes still pass through here to retire
                done    = 1'b1;
                state_d = S_IDLE;
                if (op == OP_LDI) begin
                    regEn = 1'b1;
                    litEn = 1'b1;
                    SA    = rd;
                    lit   = imm8;
                end else if (op == OP_ALU) begin
                    regEn  = 1'b1;
                    SA     = rd;
                    SB     = rs;
                    alu_op = aop;
                end
            end
            S_MEMW: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(imm8);
                if (op == OP_ST) begin
                    mem_we = 1'b1;
                    SB     = rs;
                end
                // a store retires on the ack cycle itself; a load needs writeback
                if (mem_ack) begin
                    if (op == OP_ST) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_MEMWB;
                    end
                end
            end
            S_MEMWB: begin
                regEn   = 1'b1;
                memEn   = 1'b1;
                SA      = rd;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ir_d      = accept ? instr : ir_q;
        illegal_d = illegal_q | (accept && (instr[15:12] > OP_ST));
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, done};
    end

    // Unused op codes beyond LD/ST are intentionally folded into the NOP path.
    logic unused_ok;
    assign unused_ok = ^{OP_LD};
endmodule
